// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32 decode stage: R/I-ALU/load/store/branch formats
// Valid/ready skid-free register slice with flush and a saturating illegal-instruction counter.
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter bit          EN_ITYPE = 1'b1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             reg_write,
  output logic [3:0]       alu_control,
  output logic             alu_src_imm,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  logic [3:0]      f3_alu;
  logic            dec_rw, dec_src, dec_mr, dec_mw, dec_br, dec_ill;
  logic [3:0]      dec_alu;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    f3_alu = ALU_ADD;
    case (f3)
      3'b000: f3_alu = ALU_ADD;
      3'b001: f3_alu = ALU_SLL;
      3'b010: f3_alu = ALU_SLT;
      3'b011: f3_alu = ALU_SLTU;
      3'b100: f3_alu = ALU_XOR;
      3'b101: f3_alu = ALU_SRL;
      3'b110: f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  end

  always_comb begin
    dec_rw  = 1'b0;
    dec_src = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_br  = 1'b0;
    dec_ill = 1'b0;
    dec_alu = ALU_ADD;
    dec_imm = '0;
    case (opcode)
      OP_R: begin
        dec_rw  = 1'b1;
        dec_alu = f3_alu;
        if (f7 == 7'b0100000 && f3 == 3'b000)      dec_alu = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101) dec_alu = ALU_SRA;
        else if (f7 != 7'b0000000)                 dec_ill = 1'b1;
      end
      OP_I: begin
        if (EN_ITYPE) begin
          dec_rw  = 1'b1;
          dec_src = 1'b1;
          dec_imm = imm_i;
          dec_alu = f3_alu;
          // Only the shift encodings carry a funct7 field; the rest use all 12 bits as imm.
          if (f3 == 3'b001 && f7 != 7'b0000000) dec_ill = 1'b1;
          if (f3 == 3'b101) begin
            if (f7 == 7'b0100000)      dec_alu = ALU_SRA;
            else if (f7 != 7'b0000000) dec_ill = 1'b1;
          end
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_LOAD: begin
        dec_rw  = 1'b1;
        dec_mr  = 1'b1;
        dec_src = 1'b1;
        dec_imm = imm_i;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) dec_ill = 1'b1;
      end
      OP_STORE: begin
        dec_mw  = 1'b1;
        dec_src = 1'b1;
        dec_imm = imm_s;
        if (f3[2] || f3 == 3'b011) dec_ill = 1'b1;
      end
      OP_BRANCH: begin
        dec_br  = 1'b1;
        dec_imm = imm_b;
        case (f3[2:1])
          2'b00:   dec_alu = ALU_SUB;
          2'b01:   dec_ill = 1'b1;
          2'b10:   dec_alu = ALU_SLT;
          default: dec_alu = ALU_SLTU;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_rw  = 1'b0;
      dec_src = 1'b0;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_br  = 1'b0;
      dec_alu = ALU_ADD;
      dec_imm = '0;
    end
  end

  logic accept;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  logic            valid_q, rw_q, src_q, mr_q, mw_q, br_q, ill_q;
  logic [3:0]      alu_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0] imm_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      src_q   <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
      alu_q   <= 4'b0000;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      rd_q    <= 5'd0;
      imm_q   <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      rw_q    <= dec_rw;
      src_q   <= dec_src;
      mr_q    <= dec_mr;
      mw_q    <= dec_mw;
      br_q    <= dec_br;
      ill_q   <= dec_ill;
      alu_q   <= dec_alu;
      rs1_q   <= instr[19:15];
      rs2_q   <= instr[24:20];
      rd_q    <= instr[11:7];
      imm_q   <= dec_imm;
      if (dec_ill && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign reg_write   = rw_q;
  assign alu_control = alu_q;
  assign alu_src_imm = src_q;
  assign mem_read    = mr_q;
  assign mem_write   = mw_q;
  assign branch      = br_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign imm         = imm_q;
  assign illegal     = ill_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized bench for decode_stage against a behavioural decode model
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid, reg_write, alu_src_imm, mem_read, mem_write, branch, illegal;
  logic [3:0]  alu_control;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [7:0]  illegal_cnt;

  logic        s_in_valid, s_flush, s_out_ready;
  logic [31:0] s_instr;
  logic        s_in_ready, s_out_valid, s_reg_write, s_alu_src_imm, s_mem_read, s_mem_write, s_branch, s_illegal;
  logic [3:0]  s_alu_control;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [31:0] s_imm;
  logic [1:0]  s_illegal_cnt;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .reg_write(reg_write),
    .alu_control(alu_control), .alu_src_imm(alu_src_imm), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  decode_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .instr(s_instr),
    .flush(s_flush), .out_valid(s_out_valid), .out_ready(s_out_ready), .reg_write(s_reg_write),
    .alu_control(s_alu_control), .alu_src_imm(s_alu_src_imm), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .branch(s_branch), .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd), .imm(s_imm),
    .illegal(s_illegal), .illegal_cnt(s_illegal_cnt)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        rw;
    logic [3:0]  alu;
    logic        src;
    logic        mr;
    logic        mw;
    logic        br;
    logic [31:0] imm;
    logic        ill;
    logic        imm_known;
  } dec_t;

  // Decode straight from the ISA tables; immediates via signed integer arithmetic.
  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    logic [3:0] tab [8];
    int op, f3, f7, v;
    tab = '{4'd3, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd1, 4'd0};
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    d = '0;
    d.alu = 4'd3;
    case (op)
      'h33: begin
        if (f7 == 0) d.alu = tab[f3];
        else if (f7 == 32 && f3 == 0) d.alu = 4'd4;
        else if (f7 == 32 && f3 == 5) d.alu = 4'd7;
        else d.ill = 1'b1;
        d.rw = 1'b1;
      end
      'h13: begin
        d.rw = 1'b1; d.src = 1'b1; d.imm_known = 1'b1;
        v = int'(w[31:20]); if (v >= 2048) v -= 4096; d.imm = v;
        d.alu = tab[f3];
        if (f3 == 1 && f7 != 0) d.ill = 1'b1;
        if (f3 == 5 && f7 == 32) d.alu = 4'd7;
        if (f3 == 5 && f7 != 0 && f7 != 32) d.ill = 1'b1;
      end
      'h03: begin
        d.rw = 1'b1; d.mr = 1'b1; d.src = 1'b1; d.imm_known = 1'b1;
        v = int'(w[31:20]); if (v >= 2048) v -= 4096; d.imm = v;
        if (!(f3 inside {0, 1, 2, 4, 5})) d.ill = 1'b1;
      end
      'h23: begin
        d.mw = 1'b1; d.src = 1'b1; d.imm_known = 1'b1;
        v = int'(w[31:25]) * 32 + int'(w[11:7]); if (v >= 2048) v -= 4096; d.imm = v;
        if (f3 > 2) d.ill = 1'b1;
      end
      'h63: begin
        d.br = 1'b1; d.imm_known = 1'b1;
        v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (v >= 4096) v -= 8192; d.imm = v;
        if (f3 == 2 || f3 == 3) d.ill = 1'b1;
        else d.alu = (f3 < 2) ? 4'd4 : (f3 < 6) ? 4'd8 : 4'd9;
      end
      default: d.ill = 1'b1;
    endcase
    if (d.ill) begin
      d = '0;
      d.ill = 1'b1;
      d.alu = 4'd3;
    end
    return d;
  endfunction

  logic        m_valid = 1'b0;
  int          m_cnt = 0;
  dec_t        m_e;
  logic [31:0] m_instr;
  bit          run_chk = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_cnt = 0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid = 1'b1;
      m_e = ref_dec(instr);
      m_instr = instr;
      if (m_e.ill && m_cnt < 255) m_cnt++;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("illegal_cnt", illegal_cnt, m_cnt);
      if (m_valid) begin
        chk("illegal", illegal, m_e.ill);
        chk("reg_write", reg_write, m_e.rw);
        chk("mem_read", mem_read, m_e.mr);
        chk("mem_write", mem_write, m_e.mw);
        chk("branch", branch, m_e.br);
        chk("alu_control", alu_control, m_e.alu);
        chk("rs1", rs1, m_instr[19:15]);
        chk("rs2", rs2, m_instr[24:20]);
        chk("rd", rd, m_instr[11:7]);
        if (!m_e.ill) chk("alu_src_imm", alu_src_imm, m_e.src);
        if (m_e.imm_known) chk("imm", imm, m_e.imm);
      end
    end
  end

  task automatic send(input logic [31:0] w);
    @(negedge clk); #1;
    in_valid = 1'b1;
    instr = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  ops [5];
    int r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
    w = $urandom;
    r = $urandom_range(0, 6);
    if (r < 5) w[6:0] = ops[r];
    case ($urandom_range(0, 2))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instr = '0;
    s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1; s_instr = '0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst illegal_cnt", illegal_cnt, 0);
    chk("rst alu_control", alu_control, 0);
    chk("rst imm", imm, 0);
    #1 rst_n = 1'b1;
    run_chk = 1'b1;

    send(32'h003100B3);
    chk("add out_valid", out_valid, 1);
    chk("add reg_write", reg_write, 1);
    chk("add alu", alu_control, 4'b0011);
    chk("add rs1", rs1, 2);
    chk("add rs2", rs2, 3);
    chk("add rd", rd, 1);
    chk("add illegal", illegal, 0);
    send(32'h403100B3);
    chk("sub alu", alu_control, 4'b0100);
    send(32'h403150B3);
    chk("sra alu", alu_control, 4'b0111);
    send(32'h203100B3);
    chk("badf7 illegal", illegal, 1);
    chk("badf7 reg_write", reg_write, 0);
    chk("badf7 cnt", illegal_cnt, 1);
    send(32'hFFF00093);
    chk("addi imm", imm, 32'hFFFFFFFF);
    chk("addi src", alu_src_imm, 1);
    send(32'hFE20AE23);
    chk("sw imm", imm, 32'hFFFFFFFC);
    chk("sw mem_write", mem_write, 1);
    send(32'hFE000CE3);
    chk("beq imm", imm, 32'hFFFFFFF8);
    chk("beq branch", branch, 1);
    chk("beq alu", alu_control, 4'b0100);

    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'h00A00513;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp in_ready", in_ready, 0);
      chk("bp held imm", imm, 32'hFFFFFFF8);
      chk("bp held valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp next imm", imm, 10);
    chk("bp next rd", rd, 10);

    flush = 1'b1; in_valid = 1'b1; instr = 32'h0000007F; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("flush out_valid", out_valid, 0);
    chk("flush cnt", illegal_cnt, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      instr = gen_instr();
      if (i == 1500) begin
        in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", out_valid, 0);
        chk("arst cnt", illegal_cnt, 0);
        chk("arst alu", alu_control, 0);
        chk("arst rd", rd, 0);
        chk("arst imm", imm, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
      end
    end
    @(negedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

    s_in_valid = 1'b1;
    s_instr = 32'h0000007F;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      chk("sat cnt", s_illegal_cnt, (i < 3) ? i : 3);
    end
    s_in_valid = 1'b0;
    chk("sat illegal", s_illegal, 1);
    chk("sat alu", s_alu_control, 4'b0011);
    chk("sat reg_write", s_reg_write, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32 instruction decode stage for the single-cycle datapath's pipelined successor.
- Takes a full 32-bit instruction word over a valid/ready handshake, decodes R-, I-ALU, load, store and branch formats, and registers all control fields plus the sign-extended immediate.
- Provides flush and a saturating illegal-instruction counter.
- Sits between fetch and the register file/ALU.

Parameters:
- XLEN, 32, datapath width; imm is sign-extended to XLEN.
- EN_ITYPE, 1, when 0, opcode 0010011 is illegal.
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instr is valid.
- in_ready  out  1  stage can accept.
- instr  in  32  instruction word.
- flush  in  1  discard held entry and input this cycle.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  consumer accepts.
- reg_write  out  1  rd is written.
- alu_control  out  4  ALU operation.
- alu_src_imm  out  1  ALU B operand is imm.
- mem_read  out  1  load.
- mem_write  out  1  store.
- branch  out  1  conditional branch.
- rs1, rs2, rd  out  5 each  register indices.
- imm  out  XLEN  sign-extended immediate.
- illegal  out  1  unsupported encoding.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, out_valid=0, illegal_cnt=0. in_ready=1 once out_valid=0.
- in_ready = !out_valid || out_ready (combinational).
- Accept when in_valid && in_ready && !flush. On the next edge, out_valid=1 and all fields are registered. Latency is 1 cycle.
- If out_valid && out_ready and there is no accept, out_valid→0 and fields hold their last values.
- Outputs are stable while out_valid && !out_ready.
- flush=1: out_valid→0 at the next edge. The input is not accepted and the counter is not changed. flush has priority over everything except reset.
- alu_control encoding:
  - AND 0000, OR 0001, XOR 0010, ADD 0011, SUB 0100
  - SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001
- R-type (0110011): funct3/funct7 select the op. funct7 must be 0000000, or 0100000 only for SUB (f3=000) and SRA (f3=101); anything else is illegal. reg_write=1, alu_src_imm=0.
- I-ALU (0010011, EN_ITYPE=1):
  - Same funct3 map as R-type, but f3=000 is always ADD.
  - Shifts require funct7 of 0000000 (SRAI: 0100000), else illegal.
  - reg_write=1, alu_src_imm=1, imm = sext(instr[31:20]).
- Load (0000011):
  - ADD, reg_write=1, mem_read=1, alu_src_imm=1, I-immediate.
  - funct3 ∈ {000,001,010,100,101}, else illegal.
- Store (0100011):
  - ADD, mem_write=1, alu_src_imm=1, imm = sext({instr[31:25],instr[11:7]}), reg_write=0.
  - funct3 ∈ {000,001,010}, else illegal.
- Branch (1100011):
  - SUB for f3 000/001, SLT for 100/101, SLTU for 110/111; f3 010/011 is illegal.
  - branch=1, imm = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
- Any other opcode is illegal.
- Illegal entries: illegal=1, and reg_write, mem_read, mem_write, branch are all forced to 0. alu_control=0011.
- rs1, rs2, rd are always instr[19:15], [24:20], [11:7], independent of format.
- illegal_cnt increments by 1 on each accepted illegal instruction and saturates at 2^CNT_W−1.

Test Plan:
- Reset then ADD: instr=0x003100B3 (add x1,x2,x3) → next cycle out_valid=1, reg_write=1, alu_control=0011, rs1=2, rs2=3, rd=1, illegal=0.
- SUB/SRA/illegal funct7: 0x403100B3 → 0100; 0x403150B3 → 0111; 0x203100B3 → illegal=1, reg_write=0, illegal_cnt=1.
- Immediates: addi x1,x0,-1 (0xFFF00093) → imm=0xFFFFFFFF, alu_src_imm=1; sw x2,-4(x1) (0xFE20AE23) → imm=0xFFFFFFFC, mem_write=1; beq x0,x0,-8 (0xFE000CE3) → imm=0xFFFFFFF8, branch=1, alu_control=0100.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs unchanged; out_ready=1 → next instruction appears one cycle later, none lost or duplicated.
- Flush and reset mid-operation: flush with out_valid=1 → out_valid=0 next cycle and the counter is unchanged; rst_n low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
- Saturation: CNT_W=2, feed 5 illegal opcodes (0x0000007F) → illegal_cnt=3.
